// File: rtl/prbs_gen_chk.sv
// PRBS generator / self-synchronising checker; PRBS_ERR_INJ_EN adds the 'inj' bit-corruption input.
// All outputs registered, one cycle after the en edge; no backpressure, 'en' gates every bit.
module prbs_gen_chk #(
    parameter int unsigned WIDTH  = 7,
    parameter logic [31:0] TAPS   = 32'h60,
    parameter int unsigned LOCK_N = 14,
    parameter int unsigned LOSS_N = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             rx_bit,
    input  logic             clr,
`ifdef PRBS_ERR_INJ_EN
    input  logic             inj,
`endif
    output logic [WIDTH-1:0] state,
    output logic             out_bit,
    output logic             locked,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned      MW        = $clog2(LOCK_N + 1);
    localparam int unsigned      SW        = $clog2(LOSS_N + 1);
    localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_N - 1);
    localparam logic [SW-1:0]    LOSS_LAST = SW'(LOSS_N - 1);

    typedef enum logic [1:0] {
        ST_GEN,
        ST_HUNT,
        ST_LOCKED
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic             mode_q;
    logic [MW-1:0]    match_q, match_d;
    logic [SW-1:0]    miss_q, miss_d;
    logic [WIDTH-1:0] state_d;
    logic             out_d;
    logic [CNT_W-1:0] err_d;
    logic             err_hit;
    logic             fb;
    logic             gen_bit;

    assign fb = ^(state & TAP_MASK);

`ifdef PRBS_ERR_INJ_EN
    assign gen_bit = fb ^ inj;
`else
    assign gen_bit = fb;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state;
        out_d   = out_bit;
        match_d = match_q;
        miss_d  = miss_q;
        err_hit = 1'b0;
        if (load) begin
            state_d = (seed == '0) ? ONE : seed;
            match_d = '0;
            miss_d  = '0;
            fsm_d   = mode ? ST_HUNT : ST_GEN;
        end else if (mode != mode_q) begin
            match_d = '0;
            miss_d  = '0;
            fsm_d   = mode ? ST_HUNT : ST_GEN;
        end else if (en) begin
            case (fsm_q)
                ST_GEN: begin
                    state_d = {state[WIDTH-2:0], fb};
                    out_d   = gen_bit;
                end
                ST_HUNT: begin
                    state_d = {state[WIDTH-2:0], rx_bit};
                    // an all-zero register predicts an all-zero stream; never count that as a match
                    if ((rx_bit == fb) && (state != '0)) begin
                        if (match_q == LOCK_LAST) begin
                            match_d = '0;
                            fsm_d   = ST_LOCKED;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    state_d = {state[WIDTH-2:0], fb};
                    if (rx_bit != fb) begin
                        err_hit = 1'b1;
                        if (miss_q == LOSS_LAST) begin
                            miss_d  = '0;
                            match_d = '0;
                            fsm_d   = ST_HUNT;
                        end else begin
                            miss_d = miss_q + SW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: fsm_d = ST_GEN;
            endcase
        end
    end

    always_comb begin
        err_d = err_cnt;
        if (clr) begin
            err_d = '0;
        end else if (err_hit && (err_cnt != '1)) begin
            err_d = err_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= mode ? ST_HUNT : ST_GEN;
            mode_q  <= mode;
            match_q <= '0;
            miss_q  <= '0;
            state   <= ONE;
            out_bit <= 1'b0;
            locked  <= 1'b0;
            err_cnt <= '0;
        end else begin
            fsm_q   <= fsm_d;
            mode_q  <= mode;
            match_q <= match_d;
            miss_q  <= miss_d;
            state   <= state_d;
            out_bit <= out_d;
            locked  <= (fsm_d == ST_LOCKED);
            err_cnt <= err_d;
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Scoreboard bench: generator, loopback checker, and a CNT_W=4 checker fed from a reference LFSR.
module tb_prbs_gen_chk;

    typedef enum logic [3:0] {
        SIG_G_STATE, SIG_G_OUT, SIG_G_LOCKED, SIG_G_ERR,
        SIG_C_STATE, SIG_C_OUT, SIG_C_LOCKED, SIG_C_ERR,
        SIG_S_STATE, SIG_S_OUT, SIG_S_LOCKED, SIG_S_ERR
    } sig_e;

    logic       clk;
    logic       rst_g, rst_c, rst_s;
    logic       en_g, en_s;
    logic       load_g;
    logic [6:0] seed_g;
    logic       mode_c, mode_s;
    logic       clr_c, clr_s;
    logic       rx_s, tb_rx, loop_sel;
    logic       c_rx;
`ifdef PRBS_ERR_INJ_EN
    logic       inj;
`endif

    logic [6:0]  g_state, c_state, s_state;
    logic        g_out, c_out, s_out;
    logic        g_locked, c_locked, s_locked;
    logic [15:0] g_err, c_err;
    logic [3:0]  s_err;

    sig_e        sig_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    logic [6:0] mg, mp, ms;
    logic [6:0] hand_st[6]  = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};
    logic       hand_out[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit         found;

    assign c_rx = loop_sel ? g_out : tb_rx;

    prbs_gen_chk u_gen (
        .clk(clk), .rst(rst_g), .en(en_g), .mode(1'b0), .load(load_g), .seed(seed_g),
        .rx_bit(1'b0), .clr(1'b0),
`ifdef PRBS_ERR_INJ_EN
        .inj(inj),
`endif
        .state(g_state), .out_bit(g_out), .locked(g_locked), .err_cnt(g_err)
    );

    prbs_gen_chk u_chk (
        .clk(clk), .rst(rst_c), .en(en_g), .mode(mode_c), .load(1'b0), .seed(7'h00),
        .rx_bit(c_rx), .clr(clr_c),
`ifdef PRBS_ERR_INJ_EN
        .inj(1'b0),
`endif
        .state(c_state), .out_bit(c_out), .locked(c_locked), .err_cnt(c_err)
    );

    prbs_gen_chk #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst_s), .en(en_s), .mode(mode_s), .load(1'b0), .seed(7'h00),
        .rx_bit(rx_s), .clr(clr_s),
`ifdef PRBS_ERR_INJ_EN
        .inj(1'b0),
`endif
        .state(s_state), .out_bit(s_out), .locked(s_locked), .err_cnt(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] nxt(input logic [6:0] s);
        return {s[5:0], ^(s & 7'h60)};
    endfunction

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            SIG_G_STATE:  return 32'(g_state);
            SIG_G_OUT:    return 32'(g_out);
            SIG_G_LOCKED: return 32'(g_locked);
            SIG_G_ERR:    return 32'(g_err);
            SIG_C_STATE:  return 32'(c_state);
            SIG_C_OUT:    return 32'(c_out);
            SIG_C_LOCKED: return 32'(c_locked);
            SIG_C_ERR:    return 32'(c_err);
            SIG_S_STATE:  return 32'(s_state);
            SIG_S_OUT:    return 32'(s_out);
            SIG_S_LOCKED: return 32'(s_locked);
            SIG_S_ERR:    return 32'(s_err);
            default:      return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic expect_v(input string nm, input sig_e s, input logic [31:0] v);
        sig_q.push_back(s);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one generator/loopback step, keeping the reference model in step
    task automatic gstep();
        tick();
        mp = mg;
        mg = nxt(mg);
    endtask

    // one bit into the saturation checker, optionally inverted, optionally with clr
    task automatic sbit(input logic flip, input logic c);
        rx_s  = (^(ms & 7'h60)) ^ flip;
        clr_s = c;
        en_s  = 1'b1;
        tick();
        ms    = nxt(ms);
        clr_s = 1'b0;
        en_s  = 1'b0;
    endtask

    sig_e        m_sig;
    logic [31:0] m_exp, m_act;
    string       m_name;

    always begin
        @(negedge clk);
        while (exp_q.size() > 0) begin
            m_sig  = sig_q.pop_front();
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = sample(m_sig);
            n_cmp++;
            if (m_act !== m_exp) begin
                n_mis++;
                $display("FAIL %s: got 0x%0h, want 0x%0h", m_name, m_act, m_exp);
            end
        end
    end

    initial begin
        rst_g = 1'b1; rst_c = 1'b1; rst_s = 1'b1;
        en_g = 1'b0; en_s = 1'b0; load_g = 1'b0; seed_g = 7'h00;
        mode_c = 1'b1; mode_s = 1'b1; clr_c = 1'b0; clr_s = 1'b0;
        rx_s = 1'b0; tb_rx = 1'b0; loop_sel = 1'b1;
`ifdef PRBS_ERR_INJ_EN
        inj = 1'b0;
`endif
        tick();
        tick();
        rst_g = 1'b0; rst_c = 1'b0; rst_s = 1'b0;
        expect_v("rst_state",  SIG_G_STATE,  32'h01);
        expect_v("rst_out",    SIG_G_OUT,    32'h0);
        expect_v("rst_locked", SIG_G_LOCKED, 32'h0);
        expect_v("rst_err",    SIG_G_ERR,    32'h0);
        expect_v("rst_c_lock", SIG_C_LOCKED, 32'h0);
        expect_v("rst_s_err",  SIG_S_ERR,    32'h0);

        // generator: hand-computed first six steps, then the rest of the period
        mg   = 7'h01;
        en_g = 1'b1;
        for (int i = 0; i < 6; i++) begin
            gstep();
            expect_v("gen_first_out",   SIG_G_OUT,   32'(hand_out[i]));
            expect_v("gen_first_state", SIG_G_STATE, 32'(hand_st[i]));
        end
        for (int i = 6; i < 127; i++) begin
            gstep();
            expect_v("gen_seq_state", SIG_G_STATE, 32'(mg));
        end
        expect_v("gen_period", SIG_G_STATE, 32'h01);

        en_g = 1'b0;
        tick();
        expect_v("freeze_state", SIG_G_STATE, 32'h01);
        expect_v("freeze_out",   SIG_G_OUT,   32'h1);

        en_g = 1'b1; load_g = 1'b1; seed_g = 7'h55;
        tick();
        expect_v("load_over_en",     SIG_G_STATE, 32'h55);
        expect_v("load_out_holds",   SIG_G_OUT,   32'h1);
        en_g = 1'b0; seed_g = 7'h00;
        tick();
        expect_v("load_zero_seed",   SIG_G_STATE, 32'h01);
        load_g = 1'b0;

        // loopback: checker leaves reset one generator step later so the streams line up
        rst_g = 1'b1; rst_c = 1'b1;
        tick();
        rst_g = 1'b0; en_g = 1'b1;
        tick();
        rst_c = 1'b0;
        mg = nxt(7'h01);
        for (int i = 0; i < 14; i++) begin
            gstep();
            if (i == 12) expect_v("lock_not_yet", SIG_C_LOCKED, 32'h0);
        end
        expect_v("lock_at_14",    SIG_C_LOCKED, 32'h1);
        expect_v("lock_state",    SIG_C_STATE,  32'(mp));
        expect_v("chk_out_holds", SIG_C_OUT,    32'h0);
        for (int i = 1; i <= 1000; i++) begin
            gstep();
            if (i % 250 == 0) begin
                expect_v("loop_locked", SIG_C_LOCKED, 32'h1);
                expect_v("loop_no_err", SIG_C_ERR,    32'h0);
            end
        end

`ifdef PRBS_ERR_INJ_EN
        for (int k = 0; k < 3; k++) begin
            inj = 1'b1;
            gstep();
            inj = 1'b0;
            for (int j = 0; j < 24; j++) gstep();
        end
        expect_v("inj_locked", SIG_C_LOCKED, 32'h1);
        expect_v("inj_errs",   SIG_C_ERR,    32'h3);
`endif
        en_g = 1'b0; clr_c = 1'b1;
        tick();
        clr_c = 1'b0; en_g = 1'b1;
        expect_v("clr_idle", SIG_C_ERR, 32'h0);

        // wait until the next four loopback bits are all ones, then feed zeros
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mg[0] && nxt(mg)[0] && nxt(nxt(mg))[0] && nxt(nxt(nxt(mg)))[0]) found = 1'b1;
            else gstep();
        end
        loop_sel = 1'b0; tb_rx = 1'b0;
        for (int i = 0; i < 3; i++) gstep();
        expect_v("loss_hold_3",   SIG_C_LOCKED, 32'h1);
        expect_v("loss_err_3",    SIG_C_ERR,    32'h3);
        gstep();
        expect_v("loss_drop_4",   SIG_C_LOCKED, 32'h0);
        expect_v("loss_err_4",    SIG_C_ERR,    32'h4);
        for (int i = 0; i < 150; i++) gstep();
        expect_v("no_zero_lock",  SIG_C_LOCKED, 32'h0);
        expect_v("hunt_no_count", SIG_C_ERR,    32'h4);
        en_g = 1'b0;

        // saturating 4-bit counter
        ms = 7'h01;
        for (int i = 0; i < 14; i++) sbit(1'b0, 1'b0);
        expect_v("sat_lock",  SIG_S_LOCKED, 32'h1);
        expect_v("sat_state", SIG_S_STATE,  32'(ms));
        expect_v("sat_out",   SIG_S_OUT,    32'h0);
        for (int i = 0; i < 20; i++) begin
            sbit(1'b1, 1'b0);
            sbit(1'b0, 1'b0);
            if (i == 9) expect_v("sat_ten", SIG_S_ERR, 32'd10);
        end
        expect_v("sat_max",     SIG_S_ERR,    32'd15);
        expect_v("sat_still_lk", SIG_S_LOCKED, 32'h1);
        sbit(1'b1, 1'b1);
        expect_v("clr_wins",    SIG_S_ERR,    32'd0);
        sbit(1'b0, 1'b0);
        sbit(1'b1, 1'b0);
        sbit(1'b0, 1'b0);
        sbit(1'b1, 1'b0);
        expect_v("recount",     SIG_S_ERR,    32'd2);
        mode_s = 1'b0;
        tick();
        expect_v("mode_exit",   SIG_S_LOCKED, 32'h0);
        expect_v("mode_keeps_err", SIG_S_ERR, 32'd2);

        tick();
        tick();

        n_cmp++;
        if (s_err !== 4'd2) begin
            n_mis++;
            $display("FAIL final_s_err: got 0x%0h, want 0x2", s_err);
        end
        n_cmp++;
        if (s_locked !== 1'b0) begin
            n_mis++;
            $display("FAIL final_s_locked: got %0b, want 0", s_locked);
        end
        n_cmp++;
        if (c_locked !== 1'b0) begin
            n_mis++;
            $display("FAIL final_c_locked: got %0b, want 0", c_locked);
        end
        n_cmp++;
        if (c_err !== 16'd4) begin
            n_mis++;
            $display("FAIL final_c_err: got 0x%0h, want 0x4", c_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        if (n_mis != 0) $display("FAIL: %0d mismatches", n_mis);
        else            $display("PASS");
        $finish;
    end

endmodule
